// File: rtl/riscv_icache_tag_nway_pkg.sv
// Shared types and sizing helpers for the N-way I-cache tag store.
package riscv_icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

  localparam int MAX_WAY_W = 8;
  typedef logic [MAX_WAY_W-1:0] way_idx_t;

  // Tree-PLRU needs one bit per internal node.
  function automatic int plru_w(input int ways);
    return (ways > 32'sd1) ? ways - 32'sd1 : 32'sd0;
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 32'sd1) ? $clog2(ways) : 32'sd1;
  endfunction

endpackage

// File: rtl/riscv_icache_tag_nway_plru_tree.sv
// Tree-PLRU for one set: MRU update for a touched way and victim lookup.
module icache_plru_tree
  import riscv_icache_pkg::*;
#(
  parameter int WAYS = 2,
  localparam int WAY_W = way_w(WAYS),
  localparam int PW    = plru_w(WAYS),
  localparam int PWS   = (PW > 0) ? PW : 1
) (
  input  logic [PWS-1:0]   plru_i,
  input  logic [WAY_W-1:0] way_i,
  output logic [PWS-1:0]   plru_o,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] node_s;
  logic [WAY_W-1:0] path_s;
  logic [WAY_W-1:0] vnode_s;
  logic             dir_s;

  // Walk the touched way's path (MSB first), pointing each node away from it.
  always_comb begin
    plru_o = plru_i;
    node_s = '0;
    path_s = way_i;
    if (WAYS > 1) begin
      for (int l = 0; l < WAY_W; l++) begin
        plru_o[node_s] = ~path_s[WAY_W-1];
        node_s = WAY_W'(32'(node_s) * 32'd2 + 32'd1 + 32'(path_s[WAY_W-1]));
        path_s = path_s << 32'd1;
      end
    end else begin
      plru_o = plru_i;
    end
  end

  // Victim follows the pointers from the root; bit=0 means go left.
  always_comb begin
    victim_o = '0;
    vnode_s  = '0;
    dir_s    = 1'b0;
    if (WAYS > 1) begin
      for (int l = 0; l < WAY_W; l++) begin
        dir_s    = plru_i[vnode_s];
        victim_o = WAY_W'((32'(victim_o) << 32'd1) | 32'(dir_s));
        vnode_s  = WAY_W'(32'(vnode_s) * 32'd2 + 32'd1 + 32'(dir_s));
      end
    end else begin
      victim_o = '0;
    end
  end

endmodule

// File: rtl/riscv_icache_tag_nway.sv
// N-way I-cache tag/valid store: dual lookup, tree-PLRU fills, FENCE.I flush sweep.
module riscv_icache_tag_nway
  import riscv_icache_pkg::*;
#(
  parameter int IDX  = 11,
  parameter int TAG  = 10,
  parameter int WAYS = 2,
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_en,
  input  logic [IDX-1:0]   index,
  input  logic [TAG-1:0]   tag_in,
  input  logic [IDX-1:0]   index_ma,
  input  logic [TAG-1:0]   tag_ma,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic             hit_ma,
  output logic [WAY_W-1:0] hit_way_ma,
  input  logic             fill_en,
  input  logic [IDX-1:0]   fill_index,
  input  logic [TAG-1:0]   fill_tag,
  output logic [WAY_W-1:0] fill_way,
  input  logic             flush_req,
  output logic             busy,
  output logic             flush_done
);

  localparam int SETS = 2 ** IDX;
  localparam int PW   = plru_w(WAYS);
  localparam int PWS  = (PW > 0) ? PW : 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FLUSH = FLUSH;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [WAYS-1:0] valid_q [SETS];
  logic [TAG-1:0]  tag_q   [SETS][WAYS];
  logic [PWS-1:0]  plru_q  [SETS];

  logic [1:0]     state_q, state_d;
  logic [IDX-1:0] cnt_q, cnt_d;
  logic           flush_clr_s;

  logic [WAYS-1:0]  pri_match_s, ma_match_s, fill_match_s, fill_inv_s;
  logic [PWS-1:0]   pri_plru_nxt_s, ma_plru_nxt_s, fill_plru_nxt_s;
  logic [WAY_W-1:0] fill_victim_s, pri_victim_unused, ma_victim_unused;
  logic             pri_we_s, ma_we_s, fill_we_s;

  function automatic logic [WAY_W-1:0] lowest_way(input logic [WAYS-1:0] vec);
    lowest_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      lowest_way = vec[w] ? WAY_W'(w) : lowest_way;
    end
  endfunction

  // Per-way tag compare for both lookups and the fill set.
  always_comb begin
    pri_match_s  = '0;
    ma_match_s   = '0;
    fill_match_s = '0;
    fill_inv_s   = '0;
    for (int w = 0; w < WAYS; w++) begin
      pri_match_s[w]  = valid_q[index][w] && (tag_q[index][w] == tag_in);
      ma_match_s[w]   = valid_q[index_ma][w] && (tag_q[index_ma][w] == tag_ma);
      fill_match_s[w] = valid_q[fill_index][w] && (tag_q[fill_index][w] == fill_tag);
      fill_inv_s[w]   = !valid_q[fill_index][w];
    end
  end

  // Hits are suppressed while the flush sweep owns the array.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    flush_done = (state_q == ST_DONE);
    hit        = (|pri_match_s) && !busy;
    hit_ma     = (|ma_match_s) && !busy;
    if (hit) begin
      hit_way = lowest_way(pri_match_s);
    end else begin
      hit_way = '0;
    end
    if (hit_ma) begin
      hit_way_ma = lowest_way(ma_match_s);
    end else begin
      hit_way_ma = '0;
    end
  end

  // Rewrite an existing copy first so a tag never lives in two ways.
  always_comb begin
    if (|fill_match_s) begin
      fill_way = lowest_way(fill_match_s);
    end else if (|fill_inv_s) begin
      fill_way = lowest_way(fill_inv_s);
    end else begin
      fill_way = fill_victim_s;
    end
  end

  // Write enables for the three PLRU update sources.
  always_comb begin
    fill_we_s = fill_en && !busy;
    pri_we_s  = lookup_en && hit;
    ma_we_s   = lookup_en && hit_ma && (index_ma != index);
  end

  icache_plru_tree #(.WAYS(WAYS)) u_plru_pri (
    .plru_i   (plru_q[index]),
    .way_i    (hit_way),
    .plru_o   (pri_plru_nxt_s),
    .victim_o (pri_victim_unused)
  );

  icache_plru_tree #(.WAYS(WAYS)) u_plru_ma (
    .plru_i   (plru_q[index_ma]),
    .way_i    (hit_way_ma),
    .plru_o   (ma_plru_nxt_s),
    .victim_o (ma_victim_unused)
  );

  icache_plru_tree #(.WAYS(WAYS)) u_plru_fill (
    .plru_i   (plru_q[fill_index]),
    .way_i    (fill_way),
    .plru_o   (fill_plru_nxt_s),
    .victim_o (fill_victim_s)
  );

  // Flush sequencer: one set cleared per cycle, then a one-cycle done state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush_clr_s = 1'b1;
        cnt_d       = cnt_q + IDX'(1);
        if (cnt_q == {IDX{1'b1}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and sweep counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Valid/PLRU arrays; later writes take priority: fill over primary over next-block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (flush_clr_s) begin
      valid_q[cnt_q] <= '0;
      plru_q[cnt_q]  <= '0;
    end else begin
      if (ma_we_s) begin
        plru_q[index_ma] <= ma_plru_nxt_s;
      end
      if (pri_we_s) begin
        plru_q[index] <= pri_plru_nxt_s;
      end
      if (fill_we_s) begin
        valid_q[fill_index][fill_way] <= 1'b1;
        plru_q[fill_index]            <= fill_plru_nxt_s;
      end
    end
  end

  // Tag storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      tag_q[fill_index][fill_way] <= fill_tag;
    end
  end

endmodule
